// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin front end that shares one sequential multiplier
// between N requesters. Grants one request at a time, latches its operands,
// pulses start, waits for the multiplier to finish (with a watchdog) and
// returns the product tagged with the requester index on a one-hot done.
module mult_share_ctrl #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   m_in,
    input  logic [N*WIDTH-1:0]   q_in,
    output logic [N-1:0]         ack,
    output logic [N-1:0]         done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic                 busy,
    output logic                 start,
    output logic [WIDTH-1:0]     Min,
    output logic [WIDTH-1:0]     Qin,
    input  logic                 ready,
    input  logic [2*WIDTH-1:0]   AQ
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gid;
    logic [TW-1:0]    wd;
    logic             seen_busy;

    logic             sel_valid;
    logic [IW-1:0]    sel_idx;
    logic [WIDTH-1:0] sel_m;
    logic [WIDTH-1:0] sel_q;

    assign busy = (state != IDLE);

    // Round-robin pick: first requesting index at or after ptr, wrapping around.
    always_comb begin
        int unsigned   idx;
        logic [IW-1:0] cand;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = IW'(idx);
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Operand mux for the selected requester's slices.
    always_comb begin
        sel_m = '0;
        sel_q = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (IW'(k) == sel_idx) begin
                sel_m = m_in[k*WIDTH +: WIDTH];
                sel_q = q_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Controller FSM with registered handshake, operand and result outputs.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gid       <= '0;
            wd        <= '0;
            seen_busy <= 1'b0;
            ack       <= '0;
            done      <= '0;
            start     <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            Min       <= '0;
            Qin       <= '0;
        end else begin
            ack   <= '0;
            done  <= '0;
            start <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        Min   <= sel_m;
                        Qin   <= sel_q;
                        gid   <= sel_idx;
                        ack   <= ONE << sel_idx;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    start     <= 1'b1;
                    seen_busy <= 1'b0;
                    wd        <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (!ready) begin
                        seen_busy <= 1'b1;
                    end
                    // Completion needs a low ready seen on an earlier edge; a
                    // ready that never drops falls through to the watchdog.
                    if (seen_busy && ready) begin
                        result <= AQ;
                        err    <= 1'b0;
                        done   <= ONE << gid;
                        state  <= DONE;
                    end else if (wd == TW'(TIMEOUT)) begin
                        result <= '0;
                        err    <= 1'b1;
                        done   <= ONE << gid;
                        state  <= DONE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DONE: begin
                    ptr   <= (gid == IW'(N - 1)) ? '0 : gid + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: behavioural multiplier with
// programmable latency, round-robin reference model and per-feature tests.
module tb_mult_share_ctrl;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic             clock = 1'b0;
    logic             n_rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   m_in;
    logic [N*W-1:0]   q_in;
    logic [N-1:0]     ack;
    logic [N-1:0]     done;
    logic [2*W-1:0]   result;
    logic             err;
    logic             busy;
    logic             start;
    logic [W-1:0]     Min;
    logic [W-1:0]     Qin;
    logic             ready;
    logic [2*W-1:0]   AQ;

    int tests = 0;
    int fails = 0;
    int mptr  = 0;
    bit stuck = 1'b0;
    int lat   = 8;
    int mcnt  = 0;
    logic [W-1:0] mt [N];
    logic [W-1:0] qt [N];

    mult_share_ctrl #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clock (clock),
        .n_rst (n_rst),
        .req   (req),
        .m_in  (m_in),
        .q_in  (q_in),
        .ack   (ack),
        .done  (done),
        .result(result),
        .err   (err),
        .busy  (busy),
        .start (start),
        .Min   (Min),
        .Qin   (Qin),
        .ready (ready),
        .AQ    (AQ)
    );

    always #5 clock = ~clock;

    // Behavioural multiplier: ready low for lat cycles after start, or stuck high.
    always @(posedge clock) begin
        if (!n_rst) begin
            ready <= 1'b1;
            AQ    <= '0;
            mcnt  <= 0;
        end else if (stuck) begin
            ready <= 1'b1;
        end else if (mcnt != 0) begin
            if (mcnt == 1) begin
                ready <= 1'b1;
                AQ    <= {{W{1'b0}}, Min} * {{W{1'b0}}, Qin};
            end
            mcnt <= mcnt - 1;
        end else if (start) begin
            ready <= 1'b0;
            mcnt  <= lat;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic int arb(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [2*W-1:0] prod(input int i);
        return {{W{1'b0}}, mt[i]} * {{W{1'b0}}, qt[i]};
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] m, input logic [W-1:0] q);
        mt[i] = m;
        qt[i] = q;
        m_in[i*W +: W] = m;
        q_in[i*W +: W] = q;
    endtask

    task automatic apply_reset();
        req   = '0;
        n_rst = 1'b0;
        repeat (2) @(negedge clock);
        n_rst = 1'b1;
        mptr  = 0;
    endtask

    // Client/monitor for one operation: waits for a grant, then for its done,
    // recording what was observed; the requester drops req once served.
    task automatic serve_one(input bit perturb, output logic [N-1:0] av, output logic [N-1:0] dv,
                             output logic [2*W-1:0] res, output logic e, output int gap,
                             output int st, output int stray, output logic [W-1:0] mn, output bit to);
        int c;
        int g;
        av = '0; dv = '0; res = '0; e = 1'b0; gap = 0; st = 0; stray = 0; mn = '0; to = 1'b0; g = 0;
        c = 0;
        do begin
            @(negedge clock);
            c++;
            if (done != 0) stray++;
            if (start) st++;
        end while (ack == 0 && c < 200);
        if (ack == 0) begin
            to = 1'b1;
            return;
        end
        av = ack;
        for (int i = 0; i < N; i++) if (ack[i]) g = i;
        c = 0;
        do begin
            @(negedge clock);
            c++;
            if (ack != 0) stray++;
            if (start) st++;
            if (perturb && c == 4) m_in[g*W +: W] = ~mt[g];
        end while (done == 0 && c < 200);
        gap = c;
        if (done == 0) begin
            to = 1'b1;
            return;
        end
        dv  = done;
        res = result;
        e   = err;
        mn  = Min;
        req[g] = 1'b0;
    endtask

    task automatic test_reset();
        req   = '0;
        n_rst = 1'b0;
        repeat (2) @(negedge clock);
        tests++;
        if ({ack, done, start, err, busy} !== '0)
            $display("FAIL reset_ctrl: got %b required 0", {ack, done, start, err, busy});
        tests++;
        if ({result, Min, Qin} !== '0)
            $display("FAIL reset_data: got %h required 0", {result, Min, Qin});
        if ({ack, done, start, err, busy} !== '0) fails++;
        if ({result, Min, Qin} !== '0) fails++;
        n_rst = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if ({busy, ack} !== '0) begin
            fails++;
            $display("FAIL idle_no_req: busy/ack got %b required 0", {busy, ack});
        end
    endtask

    task automatic test_single();
        logic [N-1:0] av, dv; logic [2*W-1:0] res; logic e; int gap, st, stray; logic [W-1:0] mn; bit to;
        apply_reset();
        lat = 8;
        set_op(0, 8'd3, 8'd5);
        req = 4'b0001;
        serve_one(1'b0, av, dv, res, e, gap, st, stray, mn, to);
        tests++;
        if (to) begin fails++; $display("FAIL single_wait: bounded wait expired, got none required ack/done"); end
        tests++;
        if (av !== 4'b0001) begin fails++; $display("FAIL single_ack: got %b required 0001", av); end
        tests++;
        if (dv !== 4'b0001) begin fails++; $display("FAIL single_done: got %b required 0001", dv); end
        tests++;
        if (res !== 16'd15 || e !== 1'b0) begin fails++; $display("FAIL single_result: got %0d err=%b required 15 err=0", res, e); end
        // ack in cycle G+1, done in cycle G+12 with an 8-cycle multiplier
        tests++;
        if (gap !== 11) begin fails++; $display("FAIL single_latency: got %0d required 11", gap); end
        tests++;
        if (st !== 1 || stray !== 0) begin fails++; $display("FAIL single_pulses: got start=%0d stray=%0d required 1 and 0", st, stray); end
        mptr = 1;
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] av, dv; logic [2*W-1:0] res; logic e; int gap, st, stray; logic [W-1:0] mn; bit to;
        logic [2*W-1:0] want [4];
        int tot;
        want[0] = 16'd15; want[1] = 16'd63; want[2] = 16'd65025; want[3] = 16'd0;
        apply_reset();
        lat = 8;
        set_op(0, 8'd3, 8'd5);
        set_op(1, 8'd7, 8'd9);
        set_op(2, 8'd255, 8'd255);
        set_op(3, 8'd0, 8'd200);
        req = 4'b1111;
        tot = 0;
        for (int k = 0; k < 4; k++) begin
            serve_one(1'b0, av, dv, res, e, gap, st, stray, mn, to);
            tot += st;
            tests++;
            if (av !== onehot(k) || dv !== onehot(k)) begin
                fails++;
                $display("FAIL sim_order%0d: got ack=%b done=%b required %b", k, av, dv, onehot(k));
            end
            tests++;
            if (res !== want[k] || e !== 1'b0 || stray !== 0) begin
                fails++;
                $display("FAIL sim_result%0d: got %0d err=%b stray=%0d required %0d err=0 stray=0", k, res, e, stray, want[k]);
            end
        end
        tests++;
        if (tot !== 4) begin fails++; $display("FAIL sim_starts: got %0d required 4", tot); end
        mptr = 0;
    endtask

    task automatic test_fairness();
        logic [N-1:0] av, dv; logic [2*W-1:0] res; logic e; int gap, st, stray; logic [W-1:0] mn; bit to;
        apply_reset();
        lat = 5;
        set_op(2, W'($urandom), W'($urandom));
        req = 4'b0100;
        serve_one(1'b0, av, dv, res, e, gap, st, stray, mn, to);
        tests++;
        if (av !== 4'b0100 || res !== prod(2)) begin fails++; $display("FAIL fair_first: got ack=%b res=%0d required 0100 res=%0d", av, res, prod(2)); end
        set_op(0, W'($urandom), W'($urandom));
        set_op(3, W'($urandom), W'($urandom));
        req = 4'b1001;
        serve_one(1'b0, av, dv, res, e, gap, st, stray, mn, to);
        tests++;
        if (av !== 4'b1000 || res !== prod(3)) begin fails++; $display("FAIL fair_second: got ack=%b res=%0d required 1000 res=%0d", av, res, prod(3)); end
        serve_one(1'b0, av, dv, res, e, gap, st, stray, mn, to);
        tests++;
        if (av !== 4'b0001 || res !== prod(0)) begin fails++; $display("FAIL fair_third: got ack=%b res=%0d required 0001 res=%0d", av, res, prod(0)); end
        mptr = 1;
    endtask

    task automatic test_random();
        logic [N-1:0] av, dv; logic [2*W-1:0] res; logic e; int gap, st, stray; logic [W-1:0] mn; bit to;
        int g, guard;
        for (int rnd = 0; rnd < 8; rnd++) begin
            lat = $urandom_range(1, 12);
            for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
            req = N'($urandom_range(1, 15));
            guard = 0;
            while (req != 0 && guard < N) begin
                guard++;
                g = arb(req, mptr);
                serve_one(1'($urandom_range(0, 1)), av, dv, res, e, gap, st, stray, mn, to);
                tests++;
                if (av !== onehot(g) || dv !== onehot(g)) begin
                    fails++;
                    $display("FAIL rand_grant: got ack=%b done=%b required %b", av, dv, onehot(g));
                end
                tests++;
                if (res !== prod(g) || e !== 1'b0 || mn !== mt[g]) begin
                    fails++;
                    $display("FAIL rand_result: got %0d err=%b Min=%0d required %0d err=0 Min=%0d", res, e, mn, prod(g), mt[g]);
                end
                tests++;
                if (gap !== lat + 3 || st !== 1 || stray !== 0) begin
                    fails++;
                    $display("FAIL rand_timing: got gap=%0d start=%0d stray=%0d required %0d 1 0", gap, st, stray, lat + 3);
                end
                mptr = (g + 1) % N;
            end
        end
        req = '0;
    endtask

    task automatic test_timeout();
        logic [N-1:0] av, dv; logic [2*W-1:0] res; logic e; int gap, st, stray; logic [W-1:0] mn; bit to;
        stuck = 1'b1;
        set_op(1, 8'd9, 8'd9);
        req = 4'b0010;
        serve_one(1'b0, av, dv, res, e, gap, st, stray, mn, to);
        tests++;
        if (dv !== 4'b0010 || e !== 1'b1 || res !== '0) begin
            fails++;
            $display("FAIL timeout_done: got done=%b err=%b res=%0d required 0010 1 0", dv, e, res);
        end
        // one ISSUE cycle followed by TIMEOUT+1 WAIT cycles
        tests++;
        if (gap !== TO + 2) begin fails++; $display("FAIL timeout_latency: got %0d required %0d", gap, TO + 2); end
        repeat (2) @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL timeout_idle: busy got %b required 0", busy); end
        mptr  = 2;
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] av, dv; logic [2*W-1:0] res; logic e; int gap, st, stray; logic [W-1:0] mn; bit to;
        int c;
        lat = 8;
        set_op(2, 8'd11, 8'd13);
        req = 4'b0100;
        c = 0;
        do begin @(negedge clock); c++; end while (ack == 0 && c < 50);
        tests++;
        if (ack !== 4'b0100) begin fails++; $display("FAIL mid_grant: got %b required 0100", ack); end
        repeat (4) @(negedge clock);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b required 1", busy); end
        n_rst = 1'b0;
        req   = '0;
        @(negedge clock);
        n_rst = 1'b1;
        tests++;
        if ({busy, ack, done, start, err} !== '0) begin
            fails++;
            $display("FAIL mid_reset_ctrl: got %b required 0", {busy, ack, done, start, err});
        end
        tests++;
        if ({result, Min, Qin} !== '0) begin
            fails++;
            $display("FAIL mid_reset_data: got %h required 0", {result, Min, Qin});
        end
        mptr = 0;
        set_op(0, W'($urandom), W'($urandom));
        set_op(3, W'($urandom), W'($urandom));
        req = 4'b1001;
        serve_one(1'b0, av, dv, res, e, gap, st, stray, mn, to);
        tests++;
        if (stray !== 0 || av !== 4'b0001 || dv !== 4'b0001 || res !== prod(0)) begin
            fails++;
            $display("FAIL mid_after: got stray=%0d ack=%b done=%b res=%0d required 0 0001 0001 %0d", stray, av, dv, res, prod(0));
        end
        req  = '0;
        mptr = 1;
    endtask

    task automatic test_operand_stability();
        logic [N-1:0] av, dv; logic [2*W-1:0] res; logic e; int gap, st, stray; logic [W-1:0] mn; bit to;
        apply_reset();
        lat = 8;
        set_op(0, 8'd12, 8'd11);
        req = 4'b0001;
        serve_one(1'b1, av, dv, res, e, gap, st, stray, mn, to);
        tests++;
        if (mn !== 8'd12) begin fails++; $display("FAIL stable_min: got %0d required 12", mn); end
        tests++;
        if (dv !== 4'b0001 || res !== 16'd132) begin fails++; $display("FAIL stable_result: got done=%b res=%0d required 0001 132", dv, res); end
    endtask

    initial begin
        n_rst = 1'b0;
        req   = '0;
        m_in  = '0;
        q_in  = '0;
        for (int i = 0; i < N; i++) begin
            mt[i] = '0;
            qt[i] = '0;
        end
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_random();
        test_timeout();
        test_reset_mid();
        test_operand_stability();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
